// File: rtl/pipelined_add_constant_capture_if.sv
// ----------------------------------------------------------------------------
// pipelined_add_constant_capture_if
// Purpose : generic valid/ready stream bundle used for both the capture
//           command channel and the captured-term output channel.
// Signals :
//   vld  - source has a beat on dat
//   rdy  - sink accepts the beat; transfer when vld & rdy
//   dat  - W-bit payload
// Modports:
//   master - drives vld/dat, observes rdy
//   slave  - observes vld/dat, drives rdy
// ----------------------------------------------------------------------------
interface pipelined_add_constant_capture_if #(
    parameter int W = 32
);
    logic         vld;
    logic         rdy;
    logic [W-1:0] dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/pipelined_add_constant_capture.sv
// ----------------------------------------------------------------------------
// pipelined_add_constant_capture
// Purpose : downstream consumer of the pipelined add-constant accumulator.
//           Captures a commanded number of consecutive y_w terms that follow
//           an init strobe, queues them in a small FIFO and drains the FIFO
//           over a valid/ready stream. The accumulator cannot stall, so terms
//           that meet a full FIFO are dropped and ovf is raised.
// Ports   :
//   i_clk    - clock
//   i_rst_n  - synchronous reset, active-low
//   i_y_w    - accumulator result, sampled every cycle
//   i_init   - init strobe shared with the accumulator
//   i_cmd    - command stream (slave): vld/rdy handshake, dat = term count
//   o_out    - captured-term stream (master): vld = FIFO head valid,
//              dat = FIFO head, rdy = consumer ready
//   o_done   - one-cycle pulse when a capture command completes
//   o_ovf    - sticky, at least one term dropped in the current command
// ----------------------------------------------------------------------------
module pipelined_add_constant_capture #(
    parameter int W     = 32,
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [W-1:0]                     i_y_w,
    input  logic                             i_init,
    pipelined_add_constant_capture_if.slave  i_cmd,
    pipelined_add_constant_capture_if.master o_out,
    output logic                             o_done,
    output logic                             o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPT
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_n;
    logic [CW-1:0] r_rem;
    logic          r_done;
    logic          r_ovf;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_term;
    logic          w_drop;
    logic          w_cmd_acc;
    logic          w_cmd_zero;
    logic          w_last;
    logic          w_reload;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop      = !w_empty && o_out.rdy;

    assign w_cmd_acc  = (r_state == IDLE) && i_cmd.vld;
    assign w_cmd_zero = (i_cmd.dat == '0);

    // A term is any CAPT cycle without init; a same-cycle pop frees the slot
    // a full FIFO needs, so the term is still kept in that case.
    assign w_term     = (r_state == CAPT) && !i_init;
    assign w_push     = w_term && (!w_full || w_pop);
    assign w_drop     = w_term && !w_push;
    assign w_last     = (r_rem == CNT_ONE);
    assign w_reload   = ((r_state == ARMED) || (r_state == CAPT)) && i_init;

    assign i_cmd.rdy  = (r_state == IDLE);
    assign o_out.vld  = !w_empty;
    assign o_out.dat  = r_mem[r_rptr[AW-1:0]];
    assign o_done     = r_done;
    assign o_ovf      = r_ovf;

    // Next-state logic: a zero-length command never leaves IDLE, and a
    // re-init inside CAPT stays in CAPT with the count reloaded.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cmd_acc && !w_cmd_zero) w_next_state = ARMED;
            ARMED:   if (i_init)                   w_next_state = CAPT;
            CAPT:    if (w_term && w_last)         w_next_state = IDLE;
            default:                               w_next_state = IDLE;
        endcase
    end

    // Control state, counters, flags and FIFO pointers. Reset abandons any
    // command in flight without producing a done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_cmd_acc && w_cmd_zero) || (w_term && w_last);

            if (w_cmd_acc) begin
                r_n   <= i_cmd.dat;
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_reload) begin
                r_rem <= r_n;
            end else if (w_term) begin
                r_rem <= r_rem - CNT_ONE;
            end

            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // FIFO storage holds terms verbatim; it needs no reset because the
    // pointers decide which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_y_w;
    end

endmodule

// File: tb/tb_pipelined_add_constant_capture.sv
// ----------------------------------------------------------------------------
// tb_pipelined_add_constant_capture
// Purpose : self-checking bench for pipelined_add_constant_capture. Plays the
//           role of the accumulator by driving y_w/init directly, issues
//           capture commands and collects everything popped from the output
//           stream for comparison against hand-computed expected terms.
// ----------------------------------------------------------------------------
module tb_pipelined_add_constant_capture;

    localparam int W     = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [CW-1:0]     n;
        logic [W-1:0]      aInit;
        logic [W-1:0]      inc;
        logic              rdy;
        logic [3:0]        expCount;
        logic [0:7][W-1:0] expDat;
        logic              expOvf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstN;
    logic [W-1:0] yW;
    logic         init;
    logic         done;
    logic         ovf;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int doneCount   = 0;
    int doneCyc     = -1;
    int acceptCyc   = 0;
    int initCyc     = 0;
    logic [W-1:0] rxQ [$];

    pipelined_add_constant_capture_if #(.W(CW)) cmdIf ();
    pipelined_add_constant_capture_if #(.W(W))  outIf ();

    pipelined_add_constant_capture #(
        .W     (W),
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_y_w   (yW),
        .i_init  (init),
        .i_cmd   (cmdIf),
        .o_out   (outIf),
        .o_done  (done),
        .o_ovf   (ovf)
    );

    // 10-time-unit clock; inputs change 1 unit after each rising edge.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp command acceptance, init and done.
    always @(posedge clk) cyc <= cyc + 1;

    // Collector on the falling edge: records every beat that the next rising
    // edge will pop, and every done pulse with its cycle stamp.
    always @(negedge clk) begin
        if (outIf.vld && outIf.rdy) rxQ.push_back(outIf.dat);
        if (done) begin
            doneCount = doneCount + 1;
            doneCyc   = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Compare everything collected since rxBase against the expected queue.
    task automatic checkRx(input string tag, input int rxBase,
                           input logic [W-1:0] expQ [$]);
        logic [W-1:0] got;
        checkOutput($sformatf("%s rxCount", tag), W'(rxQ.size() - rxBase),
                    W'(expQ.size()));
        for (int k = 0; k < expQ.size(); k++) begin
            got = (rxBase + k < rxQ.size()) ? rxQ[rxBase + k] : 'x;
            checkOutput($sformatf("%s data[%0d]", tag, k), got, expQ[k]);
        end
    endtask

    task automatic sendCmd(input logic [CW-1:0] n);
        cmdIf.vld = 1'b1;
        cmdIf.dat = n;
        step();
        acceptCyc = cyc;
        cmdIf.vld = 1'b0;
        cmdIf.dat = '0;
    endtask

    task automatic pulseInit();
        init = 1'b1;
        yW   = 32'hDEAD_BEEF;
        step();
        initCyc = cyc;
        init = 1'b0;
    endtask

    task automatic drain();
        yW        = '0;
        outIf.rdy = 1'b1;
        repeat (8) step();
    endtask

    // One table vector: command, one idle ARMED cycle, init, n+2 terms
    // (the extra two must be ignored), then a full drain.
    task automatic applyStimulus(input int idx, input vec_t v);
        int           rxBase   = rxQ.size();
        int           doneBase = doneCount;
        int           expDoneAt;
        logic [W-1:0] expQ [$];
        string        tag = $sformatf("vec%0d", idx);

        outIf.rdy = v.rdy;
        sendCmd(v.n);
        step();
        pulseInit();
        for (int k = 1; k <= int'(v.n) + 2; k++) begin
            yW = v.aInit + v.inc * k;
            step();
        end
        drain();

        for (int k = 0; k < int'(v.expCount); k++) expQ.push_back(v.expDat[k]);
        checkRx(tag, rxBase, expQ);
        checkOutput({tag, " ovf"}, W'(ovf), W'(v.expOvf));
        checkOutput({tag, " doneCount"}, W'(doneCount - doneBase), 32'd1);
        if (v.n == '0) expDoneAt = acceptCyc;
        else           expDoneAt = initCyc + int'(v.n);
        checkOutput({tag, " doneCycle"}, W'(doneCyc), W'(expDoneAt));
        checkOutput({tag, " emptyAfter"}, W'(outIf.vld), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        int           rxBase;
        int           doneBase;
        logic [W-1:0] expQ [$];

        vecs[0] = '{n: 8'd4, aInit: 32'd10, inc: 32'd3, rdy: 1'b1, expCount: 4'd4,
                    expDat: {32'd13, 32'd16, 32'd19, 32'd22, 32'd0, 32'd0, 32'd0, 32'd0},
                    expOvf: 1'b0};
        vecs[1] = '{n: 8'd6, aInit: 32'd10, inc: 32'd3, rdy: 1'b0, expCount: 4'd4,
                    expDat: {32'd13, 32'd16, 32'd19, 32'd22, 32'd0, 32'd0, 32'd0, 32'd0},
                    expOvf: 1'b1};
        vecs[2] = '{n: 8'd2, aInit: 32'd100, inc: 32'd1, rdy: 1'b1, expCount: 4'd2,
                    expDat: {32'd101, 32'd102, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                    expOvf: 1'b0};
        vecs[3] = '{n: 8'd0, aInit: 32'd10, inc: 32'd3, rdy: 1'b1, expCount: 4'd0,
                    expDat: {8{32'd0}}, expOvf: 1'b0};
        vecs[4] = '{n: 8'd3, aInit: 32'hFFFF_FFFE, inc: 32'd1, rdy: 1'b1, expCount: 4'd3,
                    expDat: {32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0},
                    expOvf: 1'b0};

        rstN      = 1'b0;
        yW        = '0;
        init      = 1'b0;
        cmdIf.vld = 1'b0;
        cmdIf.dat = '0;
        outIf.rdy = 1'b0;

        // Reset state, checked while reset is still held.
        step();
        step();
        checkOutput("reset outVld", W'(outIf.vld), 32'd0);
        checkOutput("reset done", W'(done), 32'd0);
        checkOutput("reset ovf", W'(ovf), 32'd0);
        checkOutput("reset cmdRdy", W'(cmdIf.rdy), 32'd1);
        rstN = 1'b1;
        step();

        for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

        // Re-init after two terms: count reloads, earlier terms stay queued.
        rxBase    = rxQ.size();
        doneBase  = doneCount;
        outIf.rdy = 1'b1;
        sendCmd(8'd5);
        step();
        pulseInit();
        yW = 32'd13; step();
        yW = 32'd16; step();
        pulseInit();
        for (int k = 1; k <= 6; k++) begin
            yW = 32'd100 + W'(k);
            step();
        end
        drain();
        expQ = '{32'd13, 32'd16, 32'd101, 32'd102, 32'd103, 32'd104, 32'd105};
        checkRx("reinit", rxBase, expQ);
        checkOutput("reinit doneCount", W'(doneCount - doneBase), 32'd1);
        checkOutput("reinit doneCycle", W'(doneCyc), W'(initCyc + 5));
        checkOutput("reinit ovf", W'(ovf), 32'd0);

        // Fill the FIFO, then push and pop each cycle while full: no drops.
        rxBase    = rxQ.size();
        doneBase  = doneCount;
        outIf.rdy = 1'b0;
        sendCmd(8'd8);
        step();
        pulseInit();
        yW = 32'd13; step();
        checkOutput("full headFirst", outIf.dat, 32'd13);
        for (int k = 2; k <= 4; k++) begin
            yW = 32'd10 + 32'd3 * W'(k);
            step();
        end
        checkOutput("full headHeld", outIf.dat, 32'd13);
        checkOutput("full vld", W'(outIf.vld), 32'd1);
        outIf.rdy = 1'b1;
        for (int k = 5; k <= 10; k++) begin
            yW = 32'd10 + 32'd3 * W'(k);
            step();
        end
        drain();
        expQ = '{32'd13, 32'd16, 32'd19, 32'd22, 32'd25, 32'd28, 32'd31, 32'd34};
        checkRx("full", rxBase, expQ);
        checkOutput("full ovf", W'(ovf), 32'd0);
        checkOutput("full doneCount", W'(doneCount - doneBase), 32'd1);

        // Reset in the middle of a capture with two entries queued.
        rxBase    = rxQ.size();
        doneBase  = doneCount;
        outIf.rdy = 1'b0;
        sendCmd(8'd6);
        step();
        pulseInit();
        yW = 32'd13; step();
        yW = 32'd16; step();
        checkOutput("midReset queued vld", W'(outIf.vld), 32'd1);
        rstN = 1'b0;
        yW   = 32'd19;
        step();
        checkOutput("midReset outVld", W'(outIf.vld), 32'd0);
        checkOutput("midReset cmdRdy", W'(cmdIf.rdy), 32'd1);
        checkOutput("midReset done", W'(done), 32'd0);
        rstN = 1'b1;
        yW   = 32'd22; step();
        pulseInit();
        for (int k = 1; k <= 4; k++) begin
            yW = 32'd200 + W'(k);
            step();
        end
        drain();
        checkOutput("midReset doneCount", W'(doneCount - doneBase), 32'd0);
        checkOutput("midReset rxCount", W'(rxQ.size() - rxBase), 32'd0);
        checkOutput("midReset ovf", W'(ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
